// File: rtl/sam_byte_packer.sv
// -----------------------------------------------------------------------------
// sam_byte_packer
//
// Packs an 8-bit byte stream into little-endian 32-bit words for the SAM core.
// A byte flagged with in_last closes the current word early. Unused upper lanes
// of that word are filled with PAD_BYTE, and out_keep marks which lanes are valid.
//
// Parameters:
//   PAD_BYTE   fill value for unused lanes of a partial final word
//   COUNT_W    width of the emitted-word counter
//
// Ports:
//   clk         rising-edge clock
//   rst         synchronous active-high reset
//   in_data     input byte
//   in_valid    input byte valid
//   in_last     input byte ends a packet (qualified by in_valid)
//   in_ready    byte accepted when in_valid && in_ready
//   out_data    packed word, byte k in bits [8k+7:8k]
//   out_keep    byte-lane valid mask for out_data
//   out_last    word ends a packet
//   out_valid   output word valid
//   out_ready   downstream ready
//   word_count  number of words transferred since reset (wraps)
// -----------------------------------------------------------------------------
module sam_byte_packer #(
    parameter logic [7:0]  PAD_BYTE = 8'h00,
    parameter int unsigned COUNT_W  = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [7:0]         in_data,
    input  logic               in_valid,
    input  logic               in_last,
    output logic               in_ready,
    output logic [31:0]        out_data,
    output logic [3:0]         out_keep,
    output logic               out_last,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COUNT_W-1:0] word_count
);

    logic [1:0]         idx_r;
    logic [23:0]        acc_r;
    logic [31:0]        out_data_r;
    logic [3:0]         out_keep_r;
    logic               out_last_r;
    logic               out_valid_r;
    logic [COUNT_W-1:0] word_count_r;

    logic               accept_s;
    logic               xfer_s;
    logic               complete_s;
    logic [31:0]        word_s;
    logic [3:0]         keep_s;

    // The input stalls whenever the output register is occupied and not
    // draining, even mid-word; this avoids needing a second word buffer.
    assign in_ready   = !rst && (!out_valid_r || out_ready);
    assign accept_s   = in_valid && in_ready;
    assign xfer_s     = out_valid_r && out_ready;
    assign complete_s = accept_s && ((idx_r == 2'd3) || in_last);

    // Assemble the word that would be emitted if the current byte completes it.
    always_comb begin
        word_s = {4{PAD_BYTE}};
        keep_s = 4'h0;
        case (idx_r)
            2'd0: begin
                word_s = {PAD_BYTE, PAD_BYTE, PAD_BYTE, in_data};
                keep_s = 4'h1;
            end
            2'd1: begin
                word_s = {PAD_BYTE, PAD_BYTE, in_data, acc_r[7:0]};
                keep_s = 4'h3;
            end
            2'd2: begin
                word_s = {PAD_BYTE, in_data, acc_r[15:0]};
                keep_s = 4'h7;
            end
            2'd3: begin
                word_s = {in_data, acc_r};
                keep_s = 4'hF;
            end
            default: begin
                word_s = {4{PAD_BYTE}};
                keep_s = 4'h0;
            end
        endcase
    end

    // Byte index and accumulator: collect lanes 0..2 until a word completes.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r <= 2'd0;
            acc_r <= 24'h000000;
        end else if (accept_s) begin
            if (complete_s) begin
                idx_r <= 2'd0;
            end else begin
                idx_r <= idx_r + 2'd1;
                case (idx_r)
                    2'd0:    acc_r[7:0]   <= in_data;
                    2'd1:    acc_r[15:8]  <= in_data;
                    2'd2:    acc_r[23:16] <= in_data;
                    default: acc_r        <= acc_r;
                endcase
            end
        end else begin
            idx_r <= idx_r;
            acc_r <= acc_r;
        end
    end

    // Output register: reload on completion (even while transferring),
    // otherwise drop valid after a transfer, otherwise hold steady.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r  <= 32'h00000000;
            out_keep_r  <= 4'h0;
            out_last_r  <= 1'b0;
            out_valid_r <= 1'b0;
        end else if (complete_s) begin
            out_data_r  <= word_s;
            out_keep_r  <= keep_s;
            out_last_r  <= in_last;
            out_valid_r <= 1'b1;
        end else if (xfer_s) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    // Transferred-word counter, wrapping naturally at its width.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_count_r <= '0;
        end else if (xfer_s) begin
            word_count_r <= word_count_r + {{(COUNT_W-1){1'b0}}, 1'b1};
        end else begin
            word_count_r <= word_count_r;
        end
    end

    assign out_data   = out_data_r;
    assign out_keep   = out_keep_r;
    assign out_last   = out_last_r;
    assign out_valid  = out_valid_r;
    assign word_count = word_count_r;

endmodule

// File: tb/tb_sam_byte_packer.sv
// -----------------------------------------------------------------------------
// tb_sam_byte_packer
//
// Self-checking bench for sam_byte_packer (PAD_BYTE = 8'hEE, COUNT_W = 4).
// A vector table covers the basic packing cases, hand-written sequences cover
// backpressure, mid-word reset and counter wrap, and a random phase compares
// the DUT against a queue-based stream model.
// -----------------------------------------------------------------------------
module tb_sam_byte_packer;

    localparam logic [7:0] PAD = 8'hEE;
    localparam int         CW  = 4;

    logic          clk;
    logic          rst;
    logic [7:0]    in_data;
    logic          in_valid;
    logic          in_last;
    logic          in_ready;
    logic [31:0]   out_data;
    logic [3:0]    out_keep;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic [CW-1:0] word_count;

    int n_cmp  = 0;
    int n_fail = 0;

    sam_byte_packer #(
        .PAD_BYTE (PAD),
        .COUNT_W  (CW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .out_data   (out_data),
        .out_keep   (out_keep),
        .out_last   (out_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .word_count (word_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [7:0]  d;
        logic        il;
        logic        ordy;
        logic        e_ird;
        logic        e_ov;
        logic [31:0] e_data;
        logic [3:0]  e_keep;
        logic        e_last;
        logic [3:0]  e_cnt;
    } vec_t;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  keep;
        logic        last;
    } word_t;

    vec_t       vt[$];
    word_t      wq[$];
    logic [7:0] bq[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'h00;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = l;
        out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Reference word built from the collected bytes of one word.
    function automatic word_t build(input logic [7:0] b[$], input logic l);
        word_t w;
        w.data = {4{PAD}};
        for (int i = 0; i < b.size(); i++) w.data[8*i +: 8] = b[i];
        w.keep = 4'((1 << b.size()) - 1);
        w.last = l;
        return w;
    endfunction

    initial begin
        logic       exp_ird;
        logic [3:0] m_cnt;
        word_t      w;

        do_reset();
        chk("reset_valid", {31'h0, out_valid}, 32'h0);
        chk("reset_data", out_data, 32'h0);
        chk("reset_keep", {28'h0, out_keep}, 32'h0);
        chk("reset_last", {31'h0, out_last}, 32'h0);
        chk("reset_count", {28'h0, word_count}, 32'h0);

        // ---------------- table-driven vectors ----------------
        // full word 11..44
        vt.push_back('{1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd0});
        vt.push_back('{1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd0});
        vt.push_back('{1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd0});
        vt.push_back('{1'b1, 8'h44, 1'b0, 1'b1, 1'b1, 1'b1, 32'h44332211, 4'hF, 1'b0, 4'd0});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd1});
        // packet 01..06 with partial tail
        vt.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd1});
        vt.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd1});
        vt.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd1});
        vt.push_back('{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0, 4'd1});
        vt.push_back('{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd2});
        vt.push_back('{1'b1, 8'h06, 1'b1, 1'b1, 1'b1, 1'b1, 32'hEEEE0605, 4'h3, 1'b1, 4'd2});
        // single-byte packet, reloading while the previous word transfers
        vt.push_back('{1'b1, 8'hAA, 1'b1, 1'b1, 1'b1, 1'b1, 32'hEEEEEEAA, 4'h1, 1'b1, 4'd3});
        // next word starts in lane 0
        vt.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd4});
        vt.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd4});
        vt.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd4});
        vt.push_back('{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 1'b1, 32'h04030201, 4'hF, 1'b0, 4'd4});
        vt.push_back('{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 4'h0, 1'b0, 4'd5});

        foreach (vt[i]) begin
            in_valid  = vt[i].iv;
            in_data   = vt[i].d;
            in_last   = vt[i].il;
            out_ready = vt[i].ordy;
            #1;
            chk($sformatf("vec%0d_in_ready", i), {31'h0, in_ready}, {31'h0, vt[i].e_ird});
            tick();
            chk($sformatf("vec%0d_valid", i), {31'h0, out_valid}, {31'h0, vt[i].e_ov});
            chk($sformatf("vec%0d_count", i), {28'h0, word_count}, {28'h0, vt[i].e_cnt});
            if (vt[i].e_ov) begin
                chk($sformatf("vec%0d_data", i), out_data, vt[i].e_data);
                chk($sformatf("vec%0d_keep", i), {28'h0, out_keep}, {28'h0, vt[i].e_keep});
                chk($sformatf("vec%0d_last", i), {31'h0, out_last}, {31'h0, vt[i].e_last});
            end
        end
        in_valid = 1'b0;

        // ---------------- backpressure ----------------
        do_reset();
        send(8'hAA, 1'b0);
        send(8'hBB, 1'b0);
        send(8'hCC, 1'b0);
        send(8'hDD, 1'b0);
        chk("bp_word", out_data, 32'hDDCCBBAA);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'h55;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk("bp_in_ready_low", {31'h0, in_ready}, 32'h0);
            tick();
            chk("bp_valid_held", {31'h0, out_valid}, 32'h1);
            chk("bp_data_stable", out_data, 32'hDDCCBBAA);
            chk("bp_keep_stable", {28'h0, out_keep}, 32'hF);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_in_ready_high", {31'h0, in_ready}, 32'h1);
        tick();
        in_valid = 1'b0;
        chk("bp_valid_drop", {31'h0, out_valid}, 32'h0);
        chk("bp_count", {28'h0, word_count}, 32'h1);
        send(8'h66, 1'b0);
        send(8'h77, 1'b0);
        send(8'h88, 1'b0);
        chk("bp_55_consumed", out_data, 32'h88776655);

        // ---------------- reset mid-word ----------------
        do_reset();
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        rst       = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_in_ready_low", {31'h0, in_ready}, 32'h0);
        tick();
        rst = 1'b0;
        #1;
        chk("rst_in_ready_after", {31'h0, in_ready}, 32'h1);
        chk("rst_valid_after", {31'h0, out_valid}, 32'h0);
        send(8'h0A, 1'b0);
        send(8'h0B, 1'b0);
        send(8'h0C, 1'b0);
        send(8'h0D, 1'b0);
        chk("rst_word", out_data, 32'h0D0C0B0A);
        chk("rst_count_before", {28'h0, word_count}, 32'h0);
        tick();
        chk("rst_count_after", {28'h0, word_count}, 32'h1);

        // ---------------- counter wrap ----------------
        do_reset();
        for (int k = 1; k <= 17; k++) begin
            send(8'(k), 1'b0);
            send(8'h10, 1'b0);
            send(8'h20, 1'b0);
            send(8'h30, 1'b0);
            out_ready = 1'b1;
            tick();
            chk($sformatf("wrap_count_%0d", k), {28'h0, word_count}, 32'(k % 16));
        end

        // ---------------- random vs stream model ----------------
        do_reset();
        m_cnt = 4'd0;
        wq.delete();
        bq.delete();
        for (int c = 0; c < 1500; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 4) == 0);
            in_data   = 8'($urandom);
            #1;
            exp_ird = (wq.size() == 0) || out_ready;
            chk("rnd_valid", {31'h0, out_valid}, {31'h0, (wq.size() > 0)});
            chk("rnd_count", {28'h0, word_count}, {28'h0, m_cnt});
            chk("rnd_in_ready", {31'h0, in_ready}, {31'h0, exp_ird});
            if (wq.size() > 0) begin
                chk("rnd_data", out_data, wq[0].data);
                chk("rnd_keep", {28'h0, out_keep}, {28'h0, wq[0].keep});
                chk("rnd_last", {31'h0, out_last}, {31'h0, wq[0].last});
                if (out_ready) begin
                    void'(wq.pop_front());
                    m_cnt = m_cnt + 4'd1;
                end
            end
            if (in_valid && exp_ird) begin
                bq.push_back(in_data);
                if (bq.size() == 4 || in_last) begin
                    w = build(bq, in_last);
                    wq.push_back(w);
                    bq.delete();
                end
            end
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
